// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and constants for the sequential 8x8 multiplier
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIGIT_W = 4;
    localparam int OP_W    = 8;
    localparam int PROD_W  = 16;

    localparam logic [3:0] SHIFT_S0 = 4'd0;
    localparam logic [3:0] SHIFT_S1 = 4'd4;
    localparam logic [3:0] SHIFT_S2 = 4'd4;
    localparam logic [3:0] SHIFT_S3 = 4'd8;

    function automatic logic [3:0] step_shift(input logic [1:0] step);
        case (step)
            2'd0:    step_shift = SHIFT_S0;
            2'd1:    step_shift = SHIFT_S1;
            2'd2:    step_shift = SHIFT_S2;
            default: step_shift = SHIFT_S3;
        endcase
    endfunction

endpackage

// File: rtl/mul4_comb.sv
// rtl/mul4_comb.sv - unsigned 4x4 combinational array multiplier
module mul4_comb
    import mul_pkg::*;
(
    input  logic [DIGIT_W-1:0]   a,
    input  logic [DIGIT_W-1:0]   b,
    output logic [2*DIGIT_W-1:0] p
);

    // One shifted row of the array per multiplier bit.
    always_comb begin
        p = '0;
        for (int i = 0; i < DIGIT_W; i++) begin
            if (b[i]) begin
                p = p + ({{DIGIT_W{1'b0}}, a} << i);
            end
        end
    end

endmodule

// File: rtl/mul8_seq_ctrl.sv
// rtl/mul8_seq_ctrl.sv - 8x8 multiply sequenced over four passes of one 4x4 multiplier
module mul8_seq_ctrl
    import mul_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] p
);

    state_t              state_q;
    state_t              state_d;
    logic [1:0]          step_q;
    logic [OP_W-1:0]     a_q;
    logic [OP_W-1:0]     b_q;
    logic [PROD_W-1:0]   acc_q;
    logic [PROD_W-1:0]   p_q;

    logic [DIGIT_W-1:0]   mul_a;
    logic [DIGIT_W-1:0]   mul_b;
    logic [2*DIGIT_W-1:0] pp;
    logic [PROD_W-1:0]    pp_shifted;
    logic [PROD_W-1:0]    sum;

    // step[0] picks the high nibble of a, step[1] the high nibble of b.
    assign mul_a = step_q[0] ? a_q[7:4] : a_q[3:0];
    assign mul_b = step_q[1] ? b_q[7:4] : b_q[3:0];

    mul4_comb u_mul4 (
        .a (mul_a),
        .b (mul_b),
        .p (pp)
    );

    assign pp_shifted = {{(PROD_W-2*DIGIT_W){1'b0}}, pp} << step_shift(step_q);
    assign sum        = acc_q + pp_shifted;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (step_q == 2'd3) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= 2'd0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        acc_q  <= '0;
                        step_q <= 2'd0;
                    end
                end
                CALC: begin
                    acc_q <= sum;
                    if (step_q == 2'd3) begin
                        p_q <= sum;
                    end else begin
                        step_q <= step_q + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign p    = p_q;

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// tb/tb_mul8_seq_ctrl.sv - randomized self-checking bench for mul8_seq_ctrl
module tb_mul8_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] p;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] p_model = 16'h0000;
    bit          mon_en  = 1'b0;

    mul8_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every done must deliver the oldest outstanding product; p holds otherwise.
    always @(negedge clk) begin
        if (mon_en) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    p_model = exp_q.pop_front();
                    chk("p_result", p, p_model);
                end
            end else begin
                chk("p_hold", p, p_model);
            end
        end
    end

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input bit poke);
        int lat;
        start = 1'b1;
        a     = ta;
        b     = tb;
        exp_q.push_back(16'(ta) * 16'(tb));
        tick();
        start = 1'b0;
        a     = 8'hFF;
        b     = 8'hFF;
        lat   = 0;
        while (!done && lat < 8) begin
            chk("busy_in_op", busy, 1);
            start = poke && (lat == 1);
            tick();
            lat++;
        end
        chk("latency", lat, 4);
        chk("busy_at_done", busy, 1);
        start = poke;
        tick();
        start = 1'b0;
        chk("busy_after", busy, 0);
        chk("done_after", done, 0);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        rst_n = 1'b0;
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_p", p, 16'h0000);
            chk("rst_done", done, 0);
            chk("rst_busy", busy, 0);
        end
        rst_n = 1'b1;
        start = 1'b0;
        tick();
        chk("post_rst_p", p, 16'h0000);
        chk("post_rst_busy", busy, 0);
        p_model = 16'h0000;
        mon_en  = 1'b1;

        run_op(8'hFF, 8'hFF, 1'b0);
        run_op(8'h07, 8'h05, 1'b0);
        run_op(8'h12, 8'h34, 1'b1);
        run_op(8'h21, 8'h43, 1'b0);

        // Abort in the middle: reset lands on the edge that would evaluate step 2.
        mon_en = 1'b0;
        start  = 1'b1;
        a      = 8'hAB;
        b      = 8'hCD;
        tick();
        start  = 1'b0;
        tick();
        tick();
        rst_n  = 1'b0;
        tick();
        rst_n  = 1'b1;
        chk("abort_p", p, 16'h0000);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_done", done, 0);
        end
        exp_q.delete();
        p_model = 16'h0000;
        mon_en  = 1'b1;
        run_op(8'h80, 8'h02, 1'b0);

        run_op(8'h00, 8'hFF, 1'b0);
        run_op(8'hFF, 8'h00, 1'b0);
        run_op(8'h01, 8'hFF, 1'b0);
        run_op(8'hF0, 8'h0F, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op(ra, rb, ($urandom_range(0, 7) == 0));
        end

        tick();
        mon_en = 1'b0;
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
